// File: rtl/io_bus_bridge.sv
// io_bus_bridge: registers one CPU IO task and runs one word-aligned bus cycle with byte lanes.
// Define IO_BRIDGE_TIMEOUT_EN to compile in the REQ-state watchdog (TIMEOUT_CYCLES).
module io_bus_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              taskValid,
  input  logic [ADDR_W-1:0] address,
  input  logic              rwCtrl,
  input  logic [1:0]        widthCtr,
  input  logic [31:0]       writeBus,
  output logic              taskReady,
  output logic              taskError,
  output logic [31:0]       readBus,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        offset, offset_next;
  logic [1:0]        width, width_next;
  logic              task_ready_next, task_error_next;
  logic [31:0]       read_bus_next;
  logic              bus_req_next, bus_we_next;
  logic [ADDR_W-1:0] bus_addr_next;
  logic [3:0]        bus_be_next;
  logic [31:0]       bus_wdata_next;
  logic              misaligned;
  logic [3:0]        be_calc;
  logic [31:0]       rdata_shift, rdata_aligned;

`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_count, wait_count_next;
`endif

  // Lane decode of the incoming request; reserved width is always rejected.
  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    case (widthCtr)
      2'd0: be_calc = 4'b0001 << address[1:0];
      2'd1: begin
        be_calc    = 4'b0011 << address[1:0];
        misaligned = address[0];
      end
      2'd2: misaligned = (address[1:0] != 2'b00);
      default: begin
        be_calc    = 4'b0000;
        misaligned = 1'b1;
      end
    endcase
  end

  always_comb begin
    rdata_shift = bus_rdata >> {offset, 3'b000};
    case (width)
      2'd0:    rdata_aligned = {24'h0, rdata_shift[7:0]};
      2'd1:    rdata_aligned = {16'h0, rdata_shift[15:0]};
      default: rdata_aligned = rdata_shift;
    endcase
  end

  always_comb begin
    state_next      = state;
    offset_next     = offset;
    width_next      = width;
    task_ready_next = 1'b0;
    task_error_next = 1'b0;
    read_bus_next   = readBus;
    bus_req_next    = bus_req;
    bus_we_next     = bus_we;
    bus_addr_next   = bus_addr;
    bus_be_next     = bus_be;
    bus_wdata_next  = bus_wdata;
`ifdef IO_BRIDGE_TIMEOUT_EN
    wait_count_next = wait_count;
`endif
    case (state)
      IDLE: begin
        if (taskValid) begin
          offset_next    = address[1:0];
          width_next     = widthCtr;
          bus_we_next    = rwCtrl;
          bus_addr_next  = {address[ADDR_W-1:2], 2'b00};
          bus_be_next    = be_calc;
          bus_wdata_next = writeBus << {address[1:0], 3'b000};
          if (misaligned) begin
            state_next      = DONE;
            task_ready_next = 1'b1;
            task_error_next = 1'b1;
          end else begin
            state_next   = REQ;
            bus_req_next = 1'b1;
`ifdef IO_BRIDGE_TIMEOUT_EN
            wait_count_next = 16'd0;
`endif
          end
        end
      end
      REQ: begin
        // bus_err beats a simultaneous bus_ack and leaves readBus untouched.
        if (bus_err) begin
          state_next      = DONE;
          bus_req_next    = 1'b0;
          task_ready_next = 1'b1;
          task_error_next = 1'b1;
        end else if (bus_ack) begin
          state_next      = DONE;
          bus_req_next    = 1'b0;
          task_ready_next = 1'b1;
          if (!bus_we) read_bus_next = rdata_aligned;
        end else begin
`ifdef IO_BRIDGE_TIMEOUT_EN
          if (wait_count == TIMEOUT_LAST) begin
            state_next      = DONE;
            bus_req_next    = 1'b0;
            task_ready_next = 1'b1;
            task_error_next = 1'b1;
          end else begin
            wait_count_next = wait_count + 16'd1;
          end
`endif
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      offset    <= 2'b00;
      width     <= 2'b00;
      taskReady <= 1'b0;
      taskError <= 1'b0;
      readBus   <= 32'h0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'h0;
`ifdef IO_BRIDGE_TIMEOUT_EN
      wait_count <= 16'd0;
`endif
    end else begin
      state     <= state_next;
      offset    <= offset_next;
      width     <= width_next;
      taskReady <= task_ready_next;
      taskError <= task_error_next;
      readBus   <= read_bus_next;
      bus_req   <= bus_req_next;
      bus_we    <= bus_we_next;
      bus_addr  <= bus_addr_next;
      bus_be    <= bus_be_next;
      bus_wdata <= bus_wdata_next;
`ifdef IO_BRIDGE_TIMEOUT_EN
      wait_count <= wait_count_next;
`endif
    end
  end

endmodule

// File: doc/io_bus_bridge.md
# io_bus_bridge

Bridges the CPU's single external IO_Interface to the system bus. It sits directly downstream of the IO_Interface selector that arbitrates between the execute and write-back stages. It registers each task and converts width and address into a word-aligned bus cycle with byte enables. It realigns read data, flags misaligned or reserved-width accesses, and reports completion and error back to the CPU.

## Interface
Parameters:
- ADDR_W, 32, address width
- TIMEOUT_CYCLES, 255, maximum bus wait cycles before error (range 1..65535)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- taskValid  in  1  CPU task request; held until taskReady
- address  in  ADDR_W  byte address
- rwCtrl  in  1  0 = read, 1 = write
- widthCtr  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- writeBus  in  32  write data, right-justified
- taskReady  out  1  one-cycle completion pulse
- taskError  out  1  error flag, valid only while taskReady = 1
- readBus  out  32  read data, right-justified and zero-extended; held until the next completion
- bus_req  out  1  bus cycle request
- bus_we  out  1  write strobe
- bus_addr  out  ADDR_W  word address, bits [1:0] = 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_ack  in  1  bus completion
- bus_err  in  1  bus error completion
- bus_rdata  in  32  read data, sampled on ack

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On taskValid, latch address, rwCtrl, widthCtr and writeBus.
  - Misalignment check: half-word with address[0] = 1, or word with address[1:0] ≠ 0, or widthCtr = 3 → go to DONE with error, no bus cycle.
  - Otherwise → REQ.
- REQ:
  - bus_req = 1; all bus_* outputs stay stable until termination.
  - bus_err = 1 → DONE with error. bus_err wins over a simultaneous bus_ack.
  - bus_ack = 1 → DONE with no error. On a read, capture bus_rdata.
- DONE:
  - taskReady = 1 for exactly one cycle, taskError per outcome → IDLE.
  - taskValid seen in DONE is not accepted; it is sampled again in IDLE on the next cycle.
- Byte enables:
  - byte: bus_be = 1 << address[1:0]
  - half: bus_be = 4'b0011 << address[1:0]
  - word: bus_be = 4'b1111
- bus_wdata = writeBus << (8 × address[1:0]).
- readBus = (bus_rdata >> (8 × address[1:0])) masked to the access width. Sign extension is not done here.
- readBus is unchanged on writes and on errored reads.
- bus_ack or bus_err outside REQ is ignored.

## Timing
- Reset values:
  - taskReady = 0, taskError = 0, readBus = 0
  - bus_req = 0, bus_we = 0, bus_addr = 0, bus_be = 0, bus_wdata = 0
  - state = IDLE, timeout counter = 0
- All outputs are registered.
- Latency:
  - Accepted in cycle N → bus_req = 1 from cycle N+1.
  - Ack in cycle M → taskReady in M+1; bus_req = 0 in M+1.
  - Minimum task latency is 2 cycles (ack on the first REQ cycle).
  - Misaligned or reserved access: taskReady = 1 with taskError = 1 in cycle N+1.
- Back-to-back tasks: the earliest next acceptance is cycle M+2, so bus_req is low for at least one cycle between tasks.
- rst in any state: returns to IDLE with reset values on the next edge. bus_req drops on that edge, and a pending ack is discarded.

## Configuration
- IO_BRIDGE_TIMEOUT_EN defined (watchdog compiled in):
  - A 16-bit counter clears on entering REQ and increments each REQ cycle without ack or err.
  - After TIMEOUT_CYCLES REQ cycles with no ack, the next cycle is DONE with taskReady = 1 and taskError = 1, and bus_req = 0.
  - Ack or err arriving on the final REQ cycle takes precedence over the timeout.
- Macro undefined: no counter; REQ waits indefinitely for ack or err.

## Test plan
- Word read: address = 0x1000, width = 2, bus_ack on the first REQ cycle with bus_rdata = 0xDEADBEEF → bus_be = 1111, taskReady 2 cycles after acceptance, readBus = 0xDEADBEEF, taskError = 0.
- Byte write: address = 0x2003, writeBus = 0x000000A5 → bus_addr = 0x2000, bus_be = 1000, bus_wdata = 0xA5000000, bus_we = 1.
- Half read: address = 0x3002, bus_rdata = 0x12345678 → readBus = 0x00001234.
- Misaligned half at 0x4001 → no bus_req; taskReady = 1 and taskError = 1 one cycle after acceptance.
- bus_ack and bus_err asserted together → taskError = 1. With IO_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES = 4 and no ack → bus_req high for exactly 4 cycles, then taskReady = 1 with taskError = 1.
- rst asserted during REQ → next cycle bus_req = 0, no taskReady. A later ack is ignored, and the next task completes normally.
